// File: rtl/seg_scan_driver_if.sv
// Display-side signal bundle for seg_scan_driver: frame data and enable in,
// registered active-low anode/cathode/decimal-point drives out.
interface seg_scan_driver_if;
  logic        enable;
  logic [19:0] seg_data;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output enable,
    output seg_data,
    input  an,
    input  seg,
    input  dp
  );

  modport slave (
    input  enable,
    input  seg_data,
    output an,
    output seg,
    output dp
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner: prescaled digit slots with a dark
// guard at the start of each slot and a frame shadow reloaded once per scan.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 16
) (
  input logic             clk,
  input logic             reset_n,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned     CntW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax    = CntW'(REFRESH_DIV - 1);
  localparam logic [19:0]     FrameBlank = {4{5'd31}};

  logic [CntW-1:0] r_cnt;
  logic [1:0]      r_idx;
  logic [19:0]     r_shadow;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;

  logic            w_tick;
  logic            w_guard;
  logic [4:0]      w_code;
  logic [6:0]      w_pat;
  logic [3:0]      w_an_d;
  logic [6:0]      w_seg_d;

  assign w_tick  = (r_cnt == CntMax);
  assign w_guard = (32'(r_cnt) < GUARD);

  always_comb begin
    w_code = 5'd31;
    unique case (r_idx)
      2'd0: w_code = r_shadow[4:0];
      2'd1: w_code = r_shadow[9:5];
      2'd2: w_code = r_shadow[14:10];
      2'd3: w_code = r_shadow[19:15];
      default: w_code = 5'd31;
    endcase
  end

  // Active-high {g,f,e,d,c,b,a}; unlisted codes are blank.
  always_comb begin
    w_pat = 7'h00;
    case (w_code)
      5'd0:    w_pat = 7'h3F;
      5'd1:    w_pat = 7'h06;
      5'd2:    w_pat = 7'h5B;
      5'd3:    w_pat = 7'h4F;
      5'd4:    w_pat = 7'h66;
      5'd5:    w_pat = 7'h6D;
      5'd6:    w_pat = 7'h7D;
      5'd7:    w_pat = 7'h07;
      5'd8:    w_pat = 7'h7F;
      5'd9:    w_pat = 7'h6F;
      5'd10:   w_pat = 7'h40;
      5'd11:   w_pat = 7'h79;
      5'd12:   w_pat = 7'h50;
      5'd13:   w_pat = 7'h38;
      5'd17:   w_pat = 7'h5C;
      5'd18:   w_pat = 7'h7C;
      5'd19:   w_pat = 7'h5E;
      default: w_pat = 7'h00;
    endcase
  end

  // Uses the pre-increment idx, so the tick cycle still drives the old digit.
  always_comb begin
    w_an_d = 4'b1111;
    if (bus.enable && !w_guard) begin
      w_an_d[r_idx] = 1'b0;
    end
    w_seg_d = bus.enable ? ~w_pat : 7'h7F;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_shadow <= FrameBlank;
      r_an     <= 4'b1111;
      r_seg    <= 7'h7F;
      r_dp     <= 1'b1;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
        // Reload only at the end of a full scan so one frame is never split.
        if (r_idx == 2'd3) begin
          r_shadow <= bus.seg_data;
        end
      end
      r_an  <= w_an_d;
      r_seg <= w_seg_d;
      r_dp  <= 1'b1;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed check of seg_scan_driver with an 8-cycle slot and 2-cycle guard;
// cycle numbers count rising edges since the first reset release.
module tb_seg_scan_driver;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;
  int   cyc;

  seg_scan_driver_if bus ();

  seg_scan_driver #(
    .REFRESH_DIV(8),
    .GUARD      (2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int target);
    while (cyc < target) adv();
  endtask

  task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es);
    n_vec++;
    assert (bus.an === ea) else begin
      n_err++;
      $error("FAIL %s @%0d: an=%b expected %b", tag, cyc, bus.an, ea);
    end
    n_vec++;
    assert (bus.seg === es) else begin
      n_err++;
      $error("FAIL %s @%0d: seg=%h expected %h", tag, cyc, bus.seg, es);
    end
    n_vec++;
    assert (bus.dp === 1'b1) else begin
      n_err++;
      $error("FAIL %s @%0d: dp=%b expected 1", tag, cyc, bus.dp);
    end
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    cyc          = 0;
    reset_n      = 1'b0;
    bus.enable   = 1'b1;
    bus.seg_data = {5'd1, 5'd2, 5'd3, 5'd4};
    repeat (3) adv();
    chk("reset", 4'b1111, 7'h7F);

    reset_n = 1'b1;
    cyc     = 0;
    // Blank shadow during the first scan, anodes still scanning.
    goto(1);   chk("first_guard", 4'b1111, 7'h7F);
    goto(3);   chk("blank_d0", 4'b1110, 7'h7F);
    goto(11);  chk("blank_d1", 4'b1101, 7'h7F);
    goto(32);  chk("blank_d3", 4'b0111, 7'h7F);
    // First load: digit 0 = code 4.
    goto(33);  chk("load_guard0", 4'b1111, 7'h19);
    goto(34);  chk("load_guard1", 4'b1111, 7'h19);
    goto(35);  chk("d0_code4", 4'b1110, 7'h19);
    goto(40);  chk("d0_slot_end", 4'b1110, 7'h19);
    goto(41);  chk("d1_guard", 4'b1111, 7'h30);
    goto(43);  chk("d1_code3", 4'b1101, 7'h30);
    goto(51);  chk("d2_code2", 4'b1011, 7'h24);
    goto(59);  chk("d3_code1", 4'b0111, 7'h79);
    goto(67);  chk("period32", 4'b1110, 7'h19);

    // Frame change while idx==1 must not leak into the current scan.
    goto(75);
    bus.seg_data = {5'd9, 5'd17, 5'd9, 5'd17};
    goto(83);  chk("old_d2", 4'b1011, 7'h24);
    goto(91);  chk("old_d3", 4'b0111, 7'h79);
    goto(99);  chk("new_d0_o", 4'b1110, 7'h23);
    goto(107); chk("new_d1_g", 4'b1101, 7'h10);
    goto(115); chk("new_d2_o", 4'b1011, 7'h23);
    goto(123); chk("new_d3_g", 4'b0111, 7'h10);

    // "-Err"
    bus.seg_data = {5'd10, 5'd11, 5'd12, 5'd12};
    goto(131); chk("err_d0_r", 4'b1110, 7'h2F);
    goto(139); chk("err_d1_r", 4'b1101, 7'h2F);
    goto(147); chk("err_d2_E", 4'b1011, 7'h06);
    goto(155); chk("err_d3_hyph", 4'b0111, 7'h3F);

    bus.seg_data = {5'd31, 5'd25, 5'd5, 5'd13};
    goto(163); chk("d0_L", 4'b1110, 7'h47);
    goto(171); chk("d1_5", 4'b1101, 7'h12);
    goto(179); chk("d2_code25", 4'b1011, 7'h7F);
    goto(187); chk("d3_code31", 4'b0111, 7'h7F);

    // Enable low for ten cycles mid-slot.
    goto(196); chk("pre_disable", 4'b1110, 7'h47);
    bus.enable = 1'b0;
    goto(197); chk("disable_1cyc", 4'b1111, 7'h7F);
    goto(201); chk("disable_mid", 4'b1111, 7'h7F);
    goto(206); chk("disable_last", 4'b1111, 7'h7F);
    bus.enable = 1'b1;
    goto(207); chk("reenable_phase", 4'b1101, 7'h12);
    goto(211); chk("reenable_d2", 4'b1011, 7'h7F);

    // One-cycle reset at cnt=5, idx=2.
    goto(213);
    reset_n = 1'b0;
    goto(214); chk("midslot_reset", 4'b1111, 7'h7F);
    reset_n = 1'b1;
    goto(215); chk("post_reset_guard", 4'b1111, 7'h7F);
    goto(217); chk("post_reset_idx0", 4'b1110, 7'h7F);
    goto(246); chk("post_reset_d3", 4'b0111, 7'h7F);
    goto(247); chk("post_reset_load", 4'b1111, 7'h47);
    goto(249); chk("post_reset_d0", 4'b1110, 7'h47);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, giving clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range 4..2^20.
REQ-002 SHALL have parameter GUARD, default 16, giving anode-off cycles at the start of each slot; legal range 0..REFRESH_DIV-1.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 enable  input  1  high: display driven; low: display dark.
REQ-007 seg_data  input  20  four 5-bit character codes; [19:15] leftmost digit (an[3]) down to [4:0] rightmost digit (an[0]).
REQ-008 an  output  4  anode selects, active-low, registered.
REQ-009 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 dp  output  1  decimal point, active-low, registered; held 1 (off).

Function
REQ-011 SHALL keep a prescaler cnt (0..REFRESH_DIV-1) that increments every cycle and wraps to 0; a tick is cnt==REFRESH_DIV-1.
REQ-012 SHALL keep a 2-bit digit index idx that advances 0->1->2->3->0 on each tick.
REQ-013 SHALL hold a 20-bit shadow copy of seg_data, loaded only on a tick where idx==3, so a full scan never mixes two frames.
REQ-014 Between loads, seg_data changes SHALL NOT affect outputs.
REQ-015 Character map (active-high {g..a} before inversion): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D (also S), 6=7D, 7=07, 8=7F, 9=6F (also g), 10=40 hyphen, 11=79 E, 12=50 r, 13=38 L, 17=5C o, 18=7C b, 19=5E d, 31 and all other codes=00 blank.
REQ-016 seg SHALL be the bitwise inverse of the mapped pattern for shadow digit idx.
REQ-017 an SHALL be 4'b1111 when cnt<GUARD or enable==0; otherwise it SHALL be low only at bit idx.
REQ-018 When enable==0, seg SHALL be 7'h7F; cnt, idx and shadow SHALL keep running and loading.
REQ-019 Outputs SHALL be registered with 1-cycle latency: values at cycle t+1 reflect cnt, idx, shadow and enable at cycle t.
REQ-020 On the tick cycle, digit selection SHALL use the pre-increment idx; the new idx takes effect from the next cycle, which has cnt==0 and therefore starts the guard.
REQ-021 dp SHALL be constant 1.

Reset
REQ-022 While reset_n==0 at a clock edge: cnt=0, idx=0, shadow=all codes 31, an=4'b1111, seg=7'h7F, dp=1.
REQ-023 Reset asserted mid-slot or mid-guard SHALL take effect at the next edge, with no partial-slot completion.
REQ-024 After reset release, the display SHALL stay blank (seg=7F) until the first shadow load at the idx 3->0 tick, 4*REFRESH_DIV cycles after release.

Verification (REFRESH_DIV=8, GUARD=2)
REQ-025 Reset, seg_data={1,2,3,4}, enable=1 -> seg=7F for the first 32 cycles; then for digit 0, an=1111 for 2 cycles, an=1110 and seg=~66 for 6 cycles, then digit 1 shows ~4F on an=1101.
REQ-026 Full scan after load -> an sequence 1110, 1101, 1011, 0111 repeats with period 32 cycles, each slot preceded by 2 dark cycles.
REQ-027 seg_data changed from {1,2,3,4} to {C_g,o,g,o} while idx==1 -> digits 2 and 3 still show old 2,1; the new frame appears starting with the next idx 0 slot.
REQ-028 Codes 10, 11, 12, 12 loaded -> seg values ~40, ~79, ~50, ~50 ("-Err"); code 31 and code 25 -> seg=7F.
REQ-029 enable deasserted for 10 cycles mid-slot -> an=1111 and seg=7F one cycle later; scan phase is unchanged when enable returns.
REQ-030 reset_n pulsed low for 1 cycle at cnt=5, idx=2 -> next cycle cnt=0, idx=0, an=1111, shadow blank.
